// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned operands.
// Latency: WIDTH+3 rising edges from the accepting edge to the done pulse.
// Backpressure: none; start is ignored while busy, and results hold until the next operation finishes.
module shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sm_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    fix_res;
    logic             ovf_u;
    logic             ovf_s;

    // Magnitudes stay WIDTH bits wide: -2^(WIDTH-1) negates to the unsigned value 2^(WIDTH-1).
    always_comb begin
        a_mag   = (sm_q && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
        b_mag   = (sm_q && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
        partial = {{WIDTH{1'b0}}, mcand} << cnt;
        fix_res = neg ? (~acc + PW'(1)) : acc;
        ovf_u   = |fix_res[PW-1:WIDTH];
        ovf_s   = !((&fix_res[PW-1:WIDTH-1]) || (~|fix_res[PW-1:WIDTH-1]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sm_q     <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sm_q  <= signed_mode;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    mcand  <= a_mag;
                    mplier <= b_mag;
                    neg    <= sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    // Multiplier shifts right so its LSB is always the bit for the current count.
                    if (mplier[0]) begin
                        acc <= acc + partial;
                    end
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        state <= FIX;
                    end
                end
                FIX: begin
                    product  <= fix_res;
                    overflow <= sm_q ? ovf_s : ovf_u;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
